// File: rtl/rx_sys.sv
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-byte holding register with ready/ack handshake and sticky error flags.
module rx_sys #(
  parameter int CLKS_PER_BIT = 1316
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxPin,
  input  logic       ack,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAITHI
  } state_t;

  logic             rx_p0;
  logic             rx_p1;
  logic             rx_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       idx_nxt;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nxt;
  logic             byte_vld;
  logic             stop_bad;

  // Stage p0/p1: synchronizer, idles high so a reset release never looks like a start bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rxPin;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    byte_vld  = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = HALF_LD;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            idx_nxt   = 3'd0;
            cnt_nxt   = BIT_LD;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shreg_nxt[bit_idx] = rx_s;
          cnt_nxt            = BIT_LD;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            byte_vld  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = S_WAITHI;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_WAITHI: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Holding register: a byte arriving with the ack that frees the slot replaces it cleanly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data      <= 8'h00;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (byte_vld && (!ready || ack)) begin
        data  <= shreg;
        ready <= 1'b1;
      end else if (!byte_vld && ack) begin
        ready <= 1'b0;
      end
      if (byte_vld && ready && !ack) begin
        overrun <= 1'b1;
      end else if (ack) begin
        overrun <= 1'b0;
      end
      if (stop_bad) begin
        frame_err <= 1'b1;
      end else if (ack) begin
        frame_err <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rx_sys.sv
// Bench for rx_sys: directed frames plus randomized traffic, checked every cycle
// against a timestamp-based model of 8N1 reception.
module tb_rx_sys;
  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       rxPin;
  logic       ack;
  logic [7:0] data;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rx_sys #(.CLKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .rxPin    (rxPin),
    .ack      (ack),
    .data     (data),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: line delay of two cycles, then frame timing from the start-sample timestamp
  logic       m_p0, m_s, in_frame, wait_hi;
  int         ts;
  logic [7:0] bits;
  logic [7:0] m_data;
  logic       m_ready, m_ferr, m_ovr, prev_ready;
  int         rise_cyc = 0;

  task automatic model_reset();
    m_p0 = 1'b1; m_s = 1'b1; in_frame = 1'b0; wait_hi = 1'b0; ts = 0; bits = 8'h00;
    m_data = 8'h00; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step(input logic pin, input logic a);
    logic rxs;
    logic byte_ev;
    logic ferr_ev;
    int   off;
    rxs = m_s; byte_ev = 1'b0; ferr_ev = 1'b0;
    if (wait_hi) begin
      if (rxs) wait_hi = 1'b0;
    end else if (!in_frame) begin
      if (!rxs) begin
        in_frame = 1'b1;
        ts = cyc + CPB / 2;
      end
    end else begin
      off = cyc - ts;
      if (off == 0) begin
        if (rxs) in_frame = 1'b0;
      end else if (off == 9 * CPB) begin
        in_frame = 1'b0;
        if (rxs) byte_ev = 1'b1;
        else begin
          ferr_ev = 1'b1;
          wait_hi = 1'b1;
        end
      end else if (off > 0 && off % CPB == 0) begin
        bits[off / CPB - 1] = rxs;
      end
    end
    if (byte_ev) begin
      if (m_ready && !a) m_ovr = 1'b1;
      else begin
        m_data = bits;
        m_ready = 1'b1;
        if (a) m_ovr = 1'b0;
      end
    end else if (a) begin
      m_ready = 1'b0;
      m_ovr = 1'b0;
    end
    if (ferr_ev) m_ferr = 1'b1;
    else if (a) m_ferr = 1'b0;
    m_s = m_p0;
    m_p0 = pin;
  endtask

  initial begin
    model_reset();
    prev_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        model_reset();
        check("rst_data", data, 8'h00);
        check("rst_ready", ready, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
      end else begin
        check("data", data, m_data);
        check("ready", ready, m_ready);
        check("frame_err", frame_err, m_ferr);
        check("overrun", overrun, m_ovr);
        check("busy", busy, in_frame || wait_hi);
        model_step(rxPin, ack);
      end
      if (ready && !prev_ready) rise_cyc = cyc;
      prev_ready = ready;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input int ack_den);
    for (int i = 0; i < n; i++) begin
      rxPin = 1'b1;
      ack = (ack_den > 0) && ($urandom_range(ack_den - 1, 0) == 0);
      tick();
    end
    ack = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input int ack_at,
                            input int ack_den, input int rst_at, output int c0);
    int pos;
    c0 = cyc;
    for (int k = 0; k < (10 + stop_low) * CPB; k++) begin
      pos = k / CPB;
      if (pos == 0) rxPin = 1'b0;
      else if (pos <= 8) rxPin = b[pos - 1];
      else rxPin = (pos - 9 < stop_low) ? 1'b0 : 1'b1;
      ack = (k == ack_at) || ((ack_den > 0) && ($urandom_range(ack_den - 1, 0) == 0));
      if (k == rst_at) reset = 1'b0;
      if (k == rst_at + 1) begin
        check("midrst_data", data, 8'h00);
        check("midrst_ready", ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
      end
      if (k == rst_at + 3) reset = 1'b1;
      tick();
    end
    ack = 1'b0;
  endtask

  initial begin
    int c0;
    logic [7:0] rb;
    int sl;
    reset = 1'b1; rxPin = 1'b1; ack = 1'b0;
    #2 reset = 1'b0;
    repeat (3) tick();
    check("init_ready", ready, 1'b0);
    check("init_data", data, 8'h00);
    reset = 1'b1;
    idle(10, 0);

    send_frame(8'hA5, 0, -1, 0, -100, c0);
    check("a5_data", data, 8'hA5);
    check("a5_ready", ready, 1'b1);
    check("a5_ferr", frame_err, 1'b0);
    check("a5_ovr", overrun, 1'b0);
    check("a5_latency", rise_cyc - c0, 155);
    pulse_ack();
    check("a5_ack_ready", ready, 1'b0);
    check("a5_ack_data", data, 8'hA5);

    send_frame(8'h3C, 0, -1, 0, -100, c0);
    send_frame(8'h7E, 0, -1, 0, -100, c0);
    check("ovr_data", data, 8'h3C);
    check("ovr_flag", overrun, 1'b1);
    pulse_ack();
    check("ovr_ack_ready", ready, 1'b0);
    check("ovr_ack_flag", overrun, 1'b0);

    send_frame(8'h55, 40, -1, 0, -100, c0);
    check("brk_ferr", frame_err, 1'b1);
    check("brk_ready", ready, 1'b0);
    idle(5, 0);
    send_frame(8'h01, 0, -1, 0, -100, c0);
    check("after_brk_data", data, 8'h01);
    check("after_brk_ready", ready, 1'b1);
    pulse_ack();
    check("ferr_cleared", frame_err, 1'b0);

    for (int i = 0; i < 5; i++) begin
      rxPin = 1'b0;
      tick();
    end
    idle(30, 0);
    check("glitch_busy", busy, 1'b0);
    check("glitch_ready", ready, 1'b0);
    check("glitch_ferr", frame_err, 1'b0);

    send_frame(8'h00, 0, -1, 0, -100, c0);
    check("zero_ready", ready, 1'b1);
    check("zero_data", data, 8'h00);
    pulse_ack();

    send_frame(8'h42, 0, -1, 0, -100, c0);
    send_frame(8'h81, 0, 154, 0, -100, c0);
    check("ackhit_data", data, 8'h81);
    check("ackhit_ready", ready, 1'b1);
    check("ackhit_ovr", overrun, 1'b0);
    pulse_ack();

    send_frame(8'hFF, 0, -1, 0, 5 * CPB + 5, c0);
    check("rstfrm_ready", ready, 1'b0);
    check("rstfrm_data", data, 8'h00);
    idle(4, 0);
    send_frame(8'h0F, 0, -1, 0, -100, c0);
    check("post_rst_data", data, 8'h0F);
    check("post_rst_ready", ready, 1'b1);
    pulse_ack();

    for (int i = 0; i < 60; i++) begin
      rb = 8'($urandom);
      sl = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      if ($urandom_range(9, 0) == 0) begin
        for (int g = 0; g < int'($urandom_range(7, 1)); g++) begin
          rxPin = 1'b0;
          tick();
        end
        idle(12, 0);
      end
      send_frame(rb, sl, -1, 20, -100, c0);
      idle(int'($urandom_range(12, 0)), 20);
    end
    idle(5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
